// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling rate, default frame width and the
// FSM state encoding reused by the transmitter-side blocks.
package uart_pkg;
  localparam int OVERSAMPLE_RATE = 16;
  localparam int DEF_BITS        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } uart_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching upward
// from last+1, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);
  localparam int IW = $clog2(N_REQ);

  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      k = (int'(last) + off) % N_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources,
// with done/timeout handling and a tick-counted inter-frame gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int BITS          = DEF_BITS,
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                     P_CLK,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         i_REQ_VALID,
  input  logic [N_REQ*BITS-1:0]    i_REQ_DATA,
  output logic [N_REQ-1:0]         o_REQ_READY,
  output logic                     o_TX_START,
  output logic [BITS-1:0]          o_TX_DATA,
  input  logic                     i_TX_DONE,
  input  logic                     i_TICK,
  output logic [$clog2(N_REQ)-1:0] o_GRANT_ID,
  output logic                     o_BUSY,
  output logic                     o_ERR
);
  localparam int          IW       = $clog2(N_REQ);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_TICKS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);
  localparam uart_state_e POST_ST  = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;

  uart_state_e      state, nxt;
  logic [15:0]      cnt;
  logic [IW-1:0]    last;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             accept;
  logic             err;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (i_REQ_VALID),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Ready only goes to a valid requester, so any pick in IDLE is a handshake.
  assign accept      = (state == ST_IDLE) && pick_any;
  assign o_REQ_READY = (state == ST_IDLE) ? pick_gnt : '0;
  assign o_TX_START  = (state == ST_START);
  assign o_BUSY      = (state != ST_IDLE);
  assign o_ERR       = err;

  always_comb begin
    nxt = state;
    err = 1'b0;
    case (state)
      ST_IDLE:  if (pick_any) nxt = ST_START;
      ST_START: nxt = ST_WAIT;
      ST_WAIT: begin
        // done takes precedence over a coincident timeout tick
        if (i_TX_DONE) begin
          nxt = POST_ST;
        end else if (i_TICK && cnt == TO_LAST) begin
          err = 1'b1;
          nxt = POST_ST;
        end
      end
      ST_GAP:   if (i_TICK && cnt == GAP_LAST) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge P_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last       <= IW'(N_REQ - 1);
      o_GRANT_ID <= '0;
      o_TX_DATA  <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if ((state == ST_WAIT || state == ST_GAP) && i_TICK && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
      if (accept) begin
        last       <= pick_idx;
        o_GRANT_ID <= pick_idx;
        o_TX_DATA  <= i_REQ_DATA[pick_idx*BITS +: BITS];
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: two instances (gap 2 and gap 0)
// share stimulus, each checked every cycle against a transaction-level model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TO  = 8;
  localparam int GAPS [2] = '{2, 0};

  logic          P_CLK = 1'b0;
  logic          reset_n;
  logic [N-1:0]  vld;
  logic [N*8-1:0] dat;
  logic          done, tick;

  logic [N-1:0]  rdy  [2];
  logic          strt [2];
  logic [7:0]    txd  [2];
  logic [1:0]    gid  [2];
  logic          busy [2];
  logic          err  [2];

  always #5 P_CLK = ~P_CLK;

  uart_tx_arbiter #(.N_REQ(N), .BITS(8), .GAP_TICKS(2), .TIMEOUT_TICKS(TO)) dut_a (
    .P_CLK(P_CLK), .reset_n(reset_n), .i_REQ_VALID(vld), .i_REQ_DATA(dat),
    .o_REQ_READY(rdy[0]), .o_TX_START(strt[0]), .o_TX_DATA(txd[0]),
    .i_TX_DONE(done), .i_TICK(tick), .o_GRANT_ID(gid[0]), .o_BUSY(busy[0]),
    .o_ERR(err[0]));

  uart_tx_arbiter #(.N_REQ(N), .BITS(8), .GAP_TICKS(0), .TIMEOUT_TICKS(TO)) dut_z (
    .P_CLK(P_CLK), .reset_n(reset_n), .i_REQ_VALID(vld), .i_REQ_DATA(dat),
    .o_REQ_READY(rdy[1]), .o_TX_START(strt[1]), .o_TX_DATA(txd[1]),
    .i_TX_DONE(done), .i_TICK(tick), .o_GRANT_ID(gid[1]), .o_BUSY(busy[1]),
    .o_ERR(err[1]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Model: phase 0 free, 1 start cycle, 2 awaiting done, 3 gap
  int         m_phase [2];
  int         m_last  [2];
  int         m_grant [2];
  logic [7:0] m_data  [2];
  int         m_wt    [2];
  int         m_gl    [2];

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++)
      if (v[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_last[d] = N - 1; m_grant[d] = 0;
      m_data[d] = 8'h00; m_wt[d] = 0; m_gl[d] = 0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int p;
      logic [N-1:0] er;
      logic ee;
      p  = pick(vld, m_last[d]);
      er = (m_phase[d] == 0 && p >= 0) ? N'(1 << p) : '0;
      ee = (m_phase[d] == 2) && tick && !done && (m_wt[d] == TO - 1);
      chk($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'(er));
      chk($sformatf("d%0d_start", d), 32'(strt[d]), 32'(m_phase[d] == 1));
      chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(m_phase[d] != 0));
      chk($sformatf("d%0d_err", d), 32'(err[d]), 32'(ee));
      chk($sformatf("d%0d_data", d), 32'(txd[d]), 32'(m_data[d]));
      chk($sformatf("d%0d_grant", d), 32'(gid[d]), 32'(m_grant[d]));
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int p;
      case (m_phase[d])
        0: begin
          p = pick(vld, m_last[d]);
          if (p >= 0) begin
            m_last[d] = p; m_grant[d] = p;
            m_data[d] = dat[p*8 +: 8];
            m_phase[d] = 1;
          end
        end
        1: begin m_phase[d] = 2; m_wt[d] = 0; end
        2: begin
          if (done || (tick && m_wt[d] == TO - 1)) begin
            m_phase[d] = (GAPS[d] == 0) ? 0 : 3;
            m_gl[d] = GAPS[d];
          end else if (tick) m_wt[d]++;
        end
        default: if (tick) begin
          m_gl[d]--;
          if (m_gl[d] == 0) m_phase[d] = 0;
        end
      endcase
    end
  endtask

  initial begin
    int n_rst = 0;
    int pct;
    reset_n = 1'b0; vld = '0; dat = '0; done = 1'b0; tick = 1'b0;
    model_reset();
    repeat (2) @(negedge P_CLK);
    #1 check_all();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge P_CLK);
      reset_n = 1'b1;
      if (((cyc >= 1600 && n_rst == 0) || (cyc >= 2400 && n_rst == 1)) && m_phase[0] == 2) begin
        reset_n = 1'b0; vld = '0; done = 1'b0; tick = 1'b0;
        #1;
        model_reset();
        check_all();
        n_rst++;
        continue;
      end
      if (cyc == 0) begin
        vld = 4'b0100; dat = {8'h00, 8'hA5, 8'h00, 8'h00};
      end else if (cyc < 300) begin
        vld = 4'b1111; dat = 32'h13121110;
      end else if (cyc < 500) begin
        vld = 4'b1010; dat = $urandom;
      end else begin
        vld = N'($urandom); dat = $urandom;
      end
      tick = (cyc < 300) ? (cyc % 3 == 0) : ($urandom % 3 == 0);
      case ((cyc / 250) % 3)
        0: pct = 0;
        1: pct = 10;
        default: pct = 30;
      endcase
      if (cyc < 300) pct = 20;
      done = (($urandom % 100) < 32'(pct));
      if (m_phase[0] == 2 && m_wt[0] == TO - 1 && tick && ($urandom % 2 == 0)) done = 1'b1;
      #1;
      check_all();
      model_step();
    end
    if (n_rst != 2) chk("reset_events", 32'(n_rst), 32'd2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter among `N_REQ` byte-producing requesters using round-robin arbitration. Accepts one byte per grant over a valid/ready handshake and drives the transmitter's start/data inputs. Waits for the transmitter's done pulse, then enforces a programmable inter-frame idle gap counted in oversample ticks. Sits between the client logic and the transmitter, sharing the same `i_TICK` oversample strobe as the receiver.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BITS`, 8: data bits per frame.
- `GAP_TICKS`, 16: idle `i_TICK`s between frames. 0 disables the gap.
- `TIMEOUT_TICKS`, 4096: `i_TICK`s allowed for the transmitter to report done before the frame is aborted.
- `P_CLK`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_REQ_VALID`  in  N_REQ  per-requester byte valid.
- `i_REQ_DATA`  in  N_REQ*BITS  requester k's byte at bits [k*BITS +: BITS].
- `o_REQ_READY`  out  N_REQ  one-hot or zero; the byte transfers when valid and ready are both high.
- `o_TX_START`  out  1  one-cycle start pulse to the transmitter.
- `o_TX_DATA`  out  BITS  latched byte; stable from the START cycle until the next accept.
- `i_TX_DONE`  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- `i_TICK`  in  1  oversample strobe, 16× baud, one `P_CLK` wide.
- `o_GRANT_ID`  out  clog2(N_REQ)  index of the last accepted requester.
- `o_BUSY`  out  1  high in every state except IDLE.
- `o_ERR`  out  1  one-cycle pulse on a timeout abort.

## Operation
- FSM states: IDLE, START, WAIT, GAP.
- **IDLE**
  - Search for a valid requester starting at `(last+1) mod N_REQ`, where `last` is the previous grant.
  - Raise `o_REQ_READY` for the first valid requester found. Ready is combinational from the state, `i_REQ_VALID` and `last`.
  - On the handshake: latch `o_TX_DATA`, set `last` and `o_GRANT_ID`, go to START.
  - If nothing is valid, stay in IDLE.
- **START**
  - `o_TX_START`=1 for exactly this cycle.
  - Clear the tick counter. Go to WAIT.
- **WAIT**
  - Count `i_TICK`s.
  - On `i_TX_DONE`: go to GAP with the counter cleared, or go straight to IDLE if `GAP_TICKS`=0.
  - If the count reaches `TIMEOUT_TICKS-1` and an `i_TICK` arrives without done: pulse `o_ERR`, then go to GAP (or IDLE if `GAP_TICKS`=0).
  - If done and the timeout tick occur in the same cycle, done wins and `o_ERR` stays low.
- **GAP**
  - Count `i_TICK`s. On the tick where the count equals `GAP_TICKS-1`, go to IDLE.
  - `i_TX_DONE` is ignored outside WAIT.
- Tick counter: 16 bits, saturating; cleared on every state entry.
- After reset, `last` = `N_REQ-1`, so requester 0 has first priority.
- A requester dropping valid before ready loses nothing; arbitration is re-evaluated every IDLE cycle.

## Timing
- Reset values (asynchronous):
  - state = IDLE
  - `o_REQ_READY` = 0
  - `o_TX_START` = 0
  - `o_TX_DATA` = 0
  - `o_GRANT_ID` = 0
  - `o_BUSY` = 0
  - `o_ERR` = 0
  - counters = 0
  - `last` = `N_REQ-1`
- Accept at cycle n gives `o_TX_START` at n+1 and `o_BUSY` high from n+1.
- Done at cycle m in WAIT:
  - with `GAP_TICKS`=0, IDLE at m+1 and the next accept is possible at m+1;
  - otherwise IDLE on the cycle after the `GAP_TICKS`-th tick following m.
- `o_REQ_READY` is never high outside IDLE. At most one ready per cycle.
- Reset asserted mid-frame: return to IDLE immediately with no START or ERR pulse. After release, priority restarts at requester 0.

## Structure
- Shared package `uart_pkg`:
  - `OVERSAMPLE_RATE` = 16
  - default `BITS`
  - the FSM state encoding typedef, also reused by the transmitter
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: request vector, `last`.
  - Outputs: one-hot grant, index, any-valid.
- FSM and counters live in `uart_tx_arbiter`.

## Test plan
- **Single requester.** `N_REQ`=4, `GAP_TICKS`=2. Requester 2 valid with 0xA5.
  - Ready[2] high in the same cycle. START one cycle later with `o_TX_DATA`=0xA5 and `o_GRANT_ID`=2.
  - Done pulse then 2 ticks, then IDLE.
- **All requesters valid continuously, bytes 0x10..0x13.** Grant order 0,1,2,3,0. Each START is separated by done plus the gap; no requester is skipped.
- **Wrap and skip.** `last`=3, requesters 1 and 3 valid. Requester 1 is granted next, then requester 3.
- **Timeout.** `TIMEOUT_TICKS`=8 and done is never asserted.
  - `o_ERR` pulses once on the 8th tick, followed by the GAP state.
  - Done arriving on the same cycle as the 8th tick gives no ERR.
- **Reset in WAIT.** Assert `reset_n` low for one cycle in WAIT.
  - All outputs return to their reset values, `o_BUSY`=0.
  - The next grant goes to requester 0 even when `last` was 2.
- **Zero gap.** `GAP_TICKS`=0 with back-to-back requests. IDLE on the cycle after done, and the next START two cycles after done.
